// File: rtl/irq_controller_if.sv
// CPU-side bus and interrupt handshake bundle for irq_controller.
// dBus stays a plain inout on the controller because it is a shared tri-state data bus.
interface irq_controller_if #(
  parameter int ABUS_WIDTH = 32
);
  logic [ABUS_WIDTH-1:0] aBus;
  logic                  wrtEn;
  logic                  intAck;
  logic                  intDone;
  logic                  intReq;
  logic [3:0]            intVec;

  modport master (output aBus, wrtEn, intAck, intDone, input intReq, intVec);
  modport slave  (input aBus, wrtEn, intAck, intDone, output intReq, intVec);
endinterface

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller: edge capture, masking, lowest-index priority, req/ack/done FSM.
// Optional overflow counter at BASE+0x10 is built when IRQ_OVF_COUNT_EN is defined.
//
// state   | meaning
// ST_IDLE | no request outstanding; waiting for GIE and an eligible pending source
// ST_REQ  | intReq high, intVec stable, waiting for intAck (or a cancel)
// ST_SVC  | handler running for intVec, waiting for intDone
module irq_controller #(
  parameter int          ABUS_WIDTH = 32,
  parameter int          DBUS_WIDTH = 32,
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] BASE_ADDR  = 32'hF0000200
) (
  input  logic                  clk,
  input  logic                  reset,
  irq_controller_if.slave       bus,
  inout  wire  [DBUS_WIDTH-1:0] dBus,
  input  logic [NUM_SRC-1:0]    irqIn
);
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SVC} state_t;

  state_t               r_state, w_state_nxt;
  logic [NUM_SRC-1:0]   r_irq_prev, r_pend, r_mask;
  logic                 r_gie, r_int_req, w_int_req_nxt;
  logic [3:0]           r_int_vec, w_int_vec_nxt, w_sel;
  logic [NUM_SRC-1:0]   w_edge, w_w1c, w_ack_clr, w_elig, w_vec_onehot;
  logic                 w_hit_pend, w_hit_mask, w_hit_vec, w_hit_ctl, w_hit_ovf, w_rd_en;
  logic                 w_wr_pend, w_wr_mask, w_wr_ctl, w_ack, w_cancel;
  logic [DBUS_WIDTH-1:0] w_rd_data;
  logic                 w_unused;

  function automatic logic [ABUS_WIDTH-1:0] reg_addr(input logic [31:0] off);
    return ABUS_WIDTH'(BASE_ADDR + off);
  endfunction

  assign w_hit_pend = (bus.aBus == reg_addr(32'h0));
  assign w_hit_mask = (bus.aBus == reg_addr(32'h4));
  assign w_hit_vec  = (bus.aBus == reg_addr(32'h8));
  assign w_hit_ctl  = (bus.aBus == reg_addr(32'hC));
  assign w_wr_pend  = bus.wrtEn && w_hit_pend;
  assign w_wr_mask  = bus.wrtEn && w_hit_mask;
  assign w_wr_ctl   = bus.wrtEn && w_hit_ctl;
  assign w_rd_en    = !bus.wrtEn && (w_hit_pend || w_hit_mask || w_hit_vec || w_hit_ctl || w_hit_ovf);
  assign w_unused   = ^dBus;

  assign w_edge       = irqIn & ~r_irq_prev;
  assign w_vec_onehot = NUM_SRC'(1) << r_int_vec;
  assign w_ack        = (r_state == ST_REQ) && bus.intAck;
  assign w_ack_clr    = w_ack ? w_vec_onehot : '0;
  assign w_w1c        = w_wr_pend ? dBus[NUM_SRC-1:0] : '0;
  // Either GIE being written low or software clearing the requested bit withdraws the request.
  assign w_cancel     = (w_wr_ctl && !dBus[0]) || (|(w_w1c & w_vec_onehot));
  assign w_elig       = r_pend & r_mask;

  always_comb begin
    w_sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_elig[i]) w_sel = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq_prev <= '0;
      r_pend     <= '0;
      r_mask     <= '0;
      r_gie      <= 1'b0;
    end else begin
      r_irq_prev <= irqIn;
      r_pend     <= (r_pend & ~(w_w1c | w_ack_clr)) | w_edge;
      if (w_wr_mask) r_mask <= dBus[NUM_SRC-1:0];
      if (w_wr_ctl)  r_gie  <= dBus[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_int_req <= 1'b0;
      r_int_vec <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_int_req <= w_int_req_nxt;
      r_int_vec <= w_int_vec_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_int_req_nxt = r_int_req;
    w_int_vec_nxt = r_int_vec;
    case (r_state)
      ST_IDLE: begin
        w_int_req_nxt = 1'b0;
        if (r_gie && (|w_elig)) begin
          w_state_nxt   = ST_REQ;
          w_int_req_nxt = 1'b1;
          w_int_vec_nxt = w_sel;
        end
      end
      ST_REQ: begin
        w_int_req_nxt = 1'b1;
        if (w_ack) begin
          w_state_nxt   = ST_SVC;
          w_int_req_nxt = 1'b0;
        end else if (w_cancel) begin
          w_state_nxt   = ST_IDLE;
          w_int_req_nxt = 1'b0;
        end
      end
      ST_SVC: begin
        w_int_req_nxt = 1'b0;
        if (bus.intDone) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_int_req_nxt = 1'b0;
      end
    endcase
  end

`ifdef IRQ_OVF_COUNT_EN
  logic [7:0] r_ovf_cnt;

  assign w_hit_ovf = (bus.aBus == reg_addr(32'h10));

  // Counts cycles in which at least one edge landed on an already-pending source.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf_cnt <= '0;
    end else if (bus.wrtEn && w_hit_ovf) begin
      r_ovf_cnt <= '0;
    end else if ((|(w_edge & r_pend)) && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end
`else
  assign w_hit_ovf = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    if (w_hit_pend) w_rd_data[NUM_SRC-1:0] = r_pend;
    if (w_hit_mask) w_rd_data[NUM_SRC-1:0] = r_mask;
    if (w_hit_vec)  w_rd_data[3:0]         = r_int_vec;
    if (w_hit_ctl)  w_rd_data[1:0]         = {(r_state != ST_IDLE), r_gie};
`ifdef IRQ_OVF_COUNT_EN
    if (w_hit_ovf)  w_rd_data[7:0]         = r_ovf_cnt;
`endif
  end

  assign dBus       = w_rd_en ? w_rd_data : 'z;
  assign bus.intReq = r_int_req;
  assign bus.intVec = r_int_vec;
endmodule
